// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_n
// Purpose  : Registered WIDTH-generic ALU with Start/Busy/Done handshake,
//            ALUout feedback as operand B and a shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_n #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [2:0]           Function,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     Bin,
  input  logic                 UseReg,
  output logic [2*WIDTH-1:0]   ALUout,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_FN_ADD    = 3'd0;
  localparam logic [2:0] c_FN_CATINV = 3'd1;
  localparam logic [2:0] c_FN_MUL    = 3'd2;
  localparam logic [2:0] c_FN_LOGIC  = 3'd3;
  localparam logic [2:0] c_FN_REDUCE = 3'd4;
  localparam logic [2:0] c_FN_SHIFT  = 3'd5;
  localparam logic [2:0] c_FN_HOLD   = 3'd6;
  localparam logic [2:0] c_FN_CLEAR  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [2*WIDTH-1:0]    r_alu, w_alu_next;
  logic                  r_done, w_done_next;
  logic [2*WIDTH-1:0]    r_mcand, w_mcand_next;
  logic [WIDTH-1:0]      r_mplier, w_mplier_next;
  logic [2*WIDTH-1:0]    r_pp, w_pp_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;

  logic [WIDTH-1:0]      w_b;
  logic [2*WIDTH-1:0]    w_bz;
  logic [2*WIDTH-1:0]    w_az;
  logic [2*WIDTH-1:0]    w_single;
  logic [2*WIDTH-1:0]    w_pp_sum;

  // Operand B always sees the result register as it was before this edge.
  assign w_b      = UseReg ? r_alu[WIDTH-1:0] : Bin;
  assign w_bz     = {{WIDTH{1'b0}}, w_b};
  assign w_az     = {{WIDTH{1'b0}}, A};
  assign w_pp_sum = r_mplier[0] ? (r_pp + r_mcand) : r_pp;

  always_comb begin
    w_single = r_alu;
    case (Function)
      c_FN_ADD:    w_single = w_az + w_bz;
      c_FN_CATINV: w_single = {A, ~w_b};
      c_FN_LOGIC:  w_single = {A | w_b, A ^ w_b};
      c_FN_REDUCE: w_single = {{(2*WIDTH-1){1'b0}}, |{A, w_b}};
      c_FN_SHIFT:  w_single = w_bz << A;
      c_FN_HOLD:   w_single = r_alu;
      c_FN_CLEAR:  w_single = '0;
      default:     w_single = r_alu;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_alu_next    = r_alu;
    w_done_next   = 1'b0;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_pp_next     = r_pp;
    w_cnt_next    = r_cnt;
    case (r_state)
      S_MUL: begin
        // Multiplier shifts right and multiplicand left, so bit 0 gates each add.
        w_pp_next     = w_pp_sum;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_alu_next   = w_pp_sum;
          w_done_next  = 1'b1;
          w_state_next = S_FINISH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        if (Start) begin
          if (Function == c_FN_MUL) begin
            w_mcand_next  = w_az;
            w_mplier_next = w_b;
            w_pp_next     = '0;
            w_cnt_next    = '0;
            w_state_next  = S_MUL;
          end else begin
            w_alu_next  = w_single;
            w_done_next = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_alu    <= '0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_pp     <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_alu    <= w_alu_next;
      r_done   <= w_done_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_pp     <= w_pp_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign ALUout = r_alu;
  assign Busy   = (r_state == S_MUL);
  assign Done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_n
// Purpose  : Directed scoreboard bench for alu_seq_n at WIDTH=4 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start4, start8, ureg, sel8;
  logic [2:0]  fn;
  logic [15:0] a, b;
  logic [7:0]  out4;
  logic [15:0] out8;
  logic        busy4, done4, busy8, done8;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb[$];

  alu_seq_n #(.WIDTH(4)) u_dut4 (
    .Clock(clk), .Reset(rst), .Start(start4), .Function(fn),
    .A(a[3:0]), .Bin(b[3:0]), .UseReg(ureg),
    .ALUout(out4), .Busy(busy4), .Done(done4)
  );

  alu_seq_n #(.WIDTH(8)) u_dut8 (
    .Clock(clk), .Reset(rst), .Start(start8), .Function(fn),
    .A(a[7:0]), .Bin(b[7:0]), .UseReg(ureg),
    .ALUout(out8), .Busy(busy8), .Done(done8)
  );

  function automatic logic [15:0] obs_out();
    return sel8 ? out8 : {8'h00, out4};
  endfunction
  function automatic logic obs_busy();
    return sel8 ? busy8 : busy4;
  endfunction
  function automatic logic obs_done();
    return sel8 ? done8 : done4;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start4 = sel8 ? 1'b0 : v;
    start8 = sel8 ? v : 1'b0;
  endtask

  task automatic check_pop(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, obs_out(), e);
    end
  endtask

  // Issues one op, counts Busy cycles, then checks the result and single Done pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [15:0] av,
                        input logic [15:0] bv, input logic u, input logic [15:0] exp,
                        input int exp_busy, input bit disturb);
    logic [15:0] held;
    int n;
    @(negedge clk);
    held = obs_out();
    fn = f; a = av; b = bv; ureg = u;
    set_start(1'b1);
    sb.push_back(exp);
    @(negedge clk);
    set_start(1'b0);
    n = 0;
    while (obs_busy() && n < 40) begin
      chk({tag, "_hold"}, obs_out(), held);
      chk({tag, "_nodone"}, 16'(obs_done()), 16'h0);
      if (disturb && n == 0) begin
        fn = 3'd0; a = 16'h0; b = 16'h0; ureg = 1'b1;
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      n++;
      @(negedge clk);
    end
    set_start(1'b0);
    chk({tag, "_busycyc"}, 16'(n), 16'(exp_busy));
    chk({tag, "_done"}, 16'(obs_done()), 16'h1);
    check_pop(tag);
    @(negedge clk);
    chk({tag, "_donelow"}, 16'(obs_done()), 16'h0);
    chk({tag, "_stable"}, obs_out(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0; sel8 = 1'b0;
    ureg = 1'b0; fn = 3'd0; a = 16'h0; b = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_out", obs_out(), 16'h0);
    chk("rst_busy", 16'(busy4), 16'h0);
    chk("rst_done", 16'(done4), 16'h0);
    rst = 1'b0;

    run_op("add_carry", 3'd0, 16'hF, 16'h1, 1'b0, 16'h10, 0, 1'b0);
    run_op("catinv",    3'd1, 16'h3, 16'h5, 1'b0, 16'h3A, 0, 1'b0);
    run_op("add_fb",    3'd0, 16'h1, 16'h0, 1'b1, 16'h0B, 0, 1'b0);
    run_op("mul_ff",    3'd2, 16'hF, 16'hF, 1'b0, 16'hE1, 4, 1'b1);
    run_op("shift3",    3'd5, 16'h3, 16'h5, 1'b0, 16'h28, 0, 1'b0);
    run_op("shift7",    3'd5, 16'h7, 16'h5, 1'b0, 16'h80, 0, 1'b0);
    run_op("shift9",    3'd5, 16'h9, 16'h5, 1'b0, 16'h00, 0, 1'b0);
    run_op("reduce0",   3'd4, 16'h0, 16'h0, 1'b0, 16'h00, 0, 1'b0);
    run_op("reduce8",   3'd4, 16'h0, 16'h8, 1'b0, 16'h01, 0, 1'b0);
    run_op("logic",     3'd3, 16'hC, 16'hA, 1'b0, 16'hE6, 0, 1'b0);
    run_op("hold",      3'd6, 16'h5, 16'h5, 1'b0, 16'hE6, 0, 1'b0);
    run_op("mul_fb",    3'd2, 16'h3, 16'h0, 1'b1, 16'h12, 4, 1'b0);
    run_op("clear",     3'd7, 16'h5, 16'h5, 1'b0, 16'h00, 0, 1'b0);

    // Start held high: each edge accumulates and Done stays asserted.
    @(negedge clk);
    fn = 3'd0; a = 16'h1; b = 16'h0; ureg = 1'b1; start4 = 1'b1;
    sb.push_back(16'h1); sb.push_back(16'h2); sb.push_back(16'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_done", 16'(done4), 16'h1);
      check_pop("b2b_out");
    end
    start4 = 1'b0;
    @(negedge clk);
    chk("b2b_donelow", 16'(done4), 16'h0);
    chk("b2b_stable", obs_out(), 16'h3);

    // Reset in the second multiply cycle aborts without a Done.
    fn = 3'd2; a = 16'h5; b = 16'h3; ureg = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("abort_busy1", 16'(busy4), 16'h1);
    @(negedge clk);
    chk("abort_busy2", 16'(busy4), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", obs_out(), 16'h0);
    chk("abort_busy", 16'(busy4), 16'h0);
    chk("abort_done", 16'(done4), 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_nodone", 16'(done4), 16'h0);
    end

    sel8 = 1'b1;
    run_op("mul8_ff",   3'd2, 16'hFF, 16'hFF, 1'b0, 16'hFE01, 8, 1'b0);
    run_op("add8",      3'd0, 16'hFF, 16'h01, 1'b0, 16'h0100, 0, 1'b0);

    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
